// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter and transaction sequencer for the
// shared slave bus. It registers the winning request onto the bus, waits for
// bReady, and returns read data with a one-cycle ack. A bounded wait-state
// timer turns a missing bReady into an error ack, so the bus cannot hang.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   m0_req/we/addr/wdata          master 0 (CPU) request, held until m0_ack
//   m0_ack, m0_err                master 0 completion pulse / error flag
//   m1_req/we/addr/wdata          master 1 (DMA/debug) request
//   m1_ack, m1_err                master 1 completion pulse / error flag
//   m_rdata                       read data for the completing master
//   bAddr, bWData, bWe, bStb      bus address, write data, write qualifier, strobe
//   bReady, bRData                slave completion and muxed read data
//   owner                         master currently or last granted
module bus_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic          m1_err,
    output logic [DW-1:0] m_rdata,
    output logic [AW-1:0] bAddr,
    output logic [DW-1:0] bWData,
    output logic          bWe,
    output logic          bStb,
    input  logic          bReady,
    input  logic [DW-1:0] bRData,
    output logic          owner
);

    localparam int unsigned TW = 8;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state, state_d;
    logic [TW-1:0] timer, timer_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] wdata_d;
    logic [DW-1:0] rdata_d;
    logic          we_d, stb_d, owner_d;
    logic          m0_ack_d, m0_err_d, m1_ack_d, m1_err_d;
    logic          grant;

    // State and output registers; every output leaves from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            bAddr   <= '0;
            bWData  <= '0;
            bWe     <= 1'b0;
            bStb    <= 1'b0;
            owner   <= 1'b1;
            m_rdata <= '0;
            m0_ack  <= 1'b0;
            m0_err  <= 1'b0;
            m1_ack  <= 1'b0;
            m1_err  <= 1'b0;
        end else begin
            state   <= state_d;
            timer   <= timer_d;
            bAddr   <= addr_d;
            bWData  <= wdata_d;
            bWe     <= we_d;
            bStb    <= stb_d;
            owner   <= owner_d;
            m_rdata <= rdata_d;
            m0_ack  <= m0_ack_d;
            m0_err  <= m0_err_d;
            m1_ack  <= m1_ack_d;
            m1_err  <= m1_err_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state;
        timer_d  = timer;
        addr_d   = bAddr;
        wdata_d  = bWData;
        we_d     = bWe;
        stb_d    = bStb;
        owner_d  = owner;
        rdata_d  = m_rdata;
        m0_ack_d = 1'b0;
        m0_err_d = 1'b0;
        m1_ack_d = 1'b0;
        m1_err_d = 1'b0;
        // Under contention the master that did not win last time goes next.
        grant    = (m0_req && m1_req) ? ~owner : m1_req;

        unique case (state)
            IDLE: begin
                stb_d = 1'b0;
                if (m0_req || m1_req) begin
                    addr_d  = grant ? m1_addr  : m0_addr;
                    wdata_d = grant ? m1_wdata : m0_wdata;
                    we_d    = grant ? m1_we    : m0_we;
                    stb_d   = 1'b1;
                    owner_d = grant;
                    timer_d = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bReady) begin
                    rdata_d  = bRData;
                    m0_ack_d = ~owner;
                    m1_ack_d = owner;
                    stb_d    = 1'b0;
                    we_d     = 1'b0;
                    state_d  = IDLE;
                end else if (timer == TIMER_LAST) begin
                    // No slave answered: complete with an error, not stale data.
                    rdata_d  = '0;
                    m0_ack_d = ~owner;
                    m1_ack_d = owner;
                    m0_err_d = ~owner;
                    m1_err_d = owner;
                    stb_d    = 1'b0;
                    we_d     = 1'b0;
                    state_d  = IDLE;
                end else begin
                    timer_d = TW'(timer + 1'b1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed self-checking bench for bus_arbiter.
// Inputs are driven 1 ns after the rising edge; outputs are sampled there too.
module tb_bus_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_ack, m0_err, m1_ack, m1_err;
    logic [DW-1:0] m_rdata;
    logic [AW-1:0] bAddr;
    logic [DW-1:0] bWData;
    logic          bWe, bStb, bReady, owner;
    logic [DW-1:0] bRData;

    int tests    = 0;
    int failures = 0;

    bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err),
        .m_rdata(m_rdata),
        .bAddr(bAddr), .bWData(bWData), .bWe(bWe), .bStb(bStb),
        .bReady(bReady), .bRData(bRData), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Watchdog so a stuck run still ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_owner;
        int   cnt;
        int   acks;
        int   prev;

        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        bReady = 0; bRData = '0;

        // Reset values
        #3;
        check("rst_bStb",    64'(bStb),    64'd0);
        check("rst_owner",   64'(owner),   64'd1);
        check("rst_acks",    64'({m0_ack, m1_ack, m0_err, m1_err}), 64'd0);
        check("rst_rdata",   64'(m_rdata), 64'd0);
        check("rst_bAddr",   64'(bAddr),   64'd0);
        tick; tick;
        rst = 1'b0;
        tick;

        // Zero-wait-state read by m0
        m0_req = 1; m0_we = 0; m0_addr = 32'h0000_0010;
        bReady = 1; bRData = 32'h1234_5678;
        tick;
        check("rd_bStb",  64'(bStb),  64'd1);
        check("rd_bAddr", 64'(bAddr), 64'h10);
        check("rd_bWe",   64'(bWe),   64'd0);
        check("rd_owner", 64'(owner), 64'd0);
        tick;
        check("rd_ack",   64'(m0_ack),  64'd1);
        check("rd_err",   64'(m0_err),  64'd0);
        check("rd_rdata", 64'(m_rdata), 64'h1234_5678);
        check("rd_stb0",  64'(bStb),    64'd0);
        check("rd_m1ack", 64'(m1_ack),  64'd0);
        m0_req = 0;
        tick;
        check("rd_ack_pulse", 64'(m0_ack), 64'd0);
        bReady = 0;

        // Round-robin from reset, both re-requesting
        rst = 1'b1; #2; rst = 1'b0;
        tick;
        m0_req = 1; m0_addr = 32'h100; m1_req = 1; m1_addr = 32'h200; m1_we = 0;
        bReady = 1;
        for (int i = 0; i < 4; i++) begin
            exp_owner = (i % 2 == 1);
            tick;
            check("rr_owner", 64'(owner), 64'(exp_owner));
            check("rr_bStb",  64'(bStb),  64'd1);
            check("rr_addr",  64'(bAddr), exp_owner ? 64'h200 : 64'h100);
            if (i < 3) begin
                if (exp_owner) m0_req = 1; else m1_req = 1;
            end
            tick;
            check("rr_acks", 64'({m0_ack, m1_ack}), exp_owner ? 64'b01 : 64'b10);
            if (exp_owner) m1_req = 0; else m0_req = 0;
        end
        bReady = 0;
        tick;

        // m1 write with 3 wait states
        m1_req = 1; m1_we = 1; m1_addr = 32'h0000_1000; m1_wdata = 32'hA5A5_A5A5;
        bRData = 32'h0BAD_F00D;
        for (int w = 0; w < 4; w++) begin
            tick;
            check("wr_bus", {bStb, bWe, bAddr[29:0], bWData}, {1'b1, 1'b1, 30'h1000, 32'hA5A5_A5A5});
            check("wr_noack", 64'({m0_ack, m1_ack}), 64'd0);
        end
        bReady = 1;
        tick;
        check("wr_ack",   64'(m1_ack),  64'd1);
        check("wr_err",   64'(m1_err),  64'd0);
        check("wr_rdata", 64'(m_rdata), 64'h0BAD_F00D);
        check("wr_we0",   64'({bStb, bWe}), 64'd0);
        m1_req = 0; m1_we = 0; bReady = 0;
        tick;
        check("wr_single_ack", 64'(m1_ack), 64'd0);

        // Timeout on unmapped address, then pending m1 served
        m0_req = 1; m0_we = 1; m0_addr = 32'hDEAD_0000; m0_wdata = 32'h1;
        m1_req = 1; m1_addr = 32'h0000_3000;
        bRData = 32'h5555_AAAA;
        tick;
        check("to_owner", 64'(owner), 64'd0);
        cnt = 0;
        while (bStb && cnt < 40) begin
            cnt++;
            tick;
        end
        check("to_stb_cycles", 64'(cnt), 64'd15);
        check("to_ack",   64'(m0_ack),  64'd1);
        check("to_err",   64'(m0_err),  64'd1);
        check("to_rdata", 64'(m_rdata), 64'd0);
        check("to_m1ack", 64'(m1_ack),  64'd0);
        m0_req = 0; m0_we = 0;
        bReady = 1; bRData = 32'h0000_CAFE;
        tick;
        check("to_next_owner", 64'(owner), 64'd1);
        check("to_next_addr",  64'(bAddr), 64'h3000);
        tick;
        check("to_m1_ack",   64'({m1_ack, m1_err}), 64'b10);
        check("to_m1_rdata", 64'(m_rdata), 64'hCAFE);
        m1_req = 0; bReady = 0;
        tick;

        // Asynchronous reset in the third BUSY cycle
        m0_req = 1; m0_addr = 32'h40;
        tick; tick; tick;
        check("ar_busy3", 64'({bStb, owner}), 64'b10);
        #2; rst = 1'b1; #1;
        check("ar_stb",   64'(bStb),  64'd0);
        check("ar_owner", 64'(owner), 64'd1);
        m0_req = 0;
        tick;
        check("ar_noack", 64'({m0_ack, m1_ack}), 64'd0);
        rst = 1'b0;
        m0_req = 1; m1_req = 1;
        tick;
        check("ar_first_grant", 64'(owner), 64'd0);
        bReady = 1;
        tick;
        check("ar_m0_ack", 64'(m0_ack), 64'd1);
        m0_req = 0;
        tick;
        check("ar_m1_grant", 64'(owner), 64'd1);
        tick;
        check("ar_m1_ack", 64'(m1_ack), 64'd1);
        m1_req = 0;
        tick;

        // m1 alone, 4 transfers at 3-cycle spacing
        m1_req = 1; m1_addr = 32'h44;
        acks = 0; prev = -1;
        for (int c = 0; c < 16; c++) begin
            tick;
            check("solo_m0_quiet", 64'({m0_ack, m0_err}), 64'd0);
            if (m1_ack) begin
                acks++;
                if (prev >= 0) check("solo_spacing", 64'(c - prev), 64'd3);
                prev = c;
                m1_req = 0;
            end else if (!m1_req && acks < 4) begin
                m1_req = 1;
            end
        end
        check("solo_acks", 64'(acks), 64'd4);
        bReady = 0;

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
